// File: rtl/reg_dump_tx.sv
// Debug register dumper: walks register indices 0..LAST_REG on a start request,
// snapshots each 32-bit word and sends it MSB byte first over a UART 8N1 line.
module reg_dump_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int LAST_REG     = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  dbg_read,
  input  logic [31:0] dbg_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int              CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]      REG_LAST = 5'(LAST_REG);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [4:0]    dbg_read_q, dbg_read_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [7:0]    cur_byte_s;
  logic [2:0]    bit_nxt_s;
  logic          bit_end_s;

  // Byte currently on the wire, most significant byte of the snapshot first.
  always_comb begin
    case (byte_q)
      2'd0:    cur_byte_s = shadow_q[31:24];
      2'd1:    cur_byte_s = shadow_q[23:16];
      2'd2:    cur_byte_s = shadow_q[15:8];
      2'd3:    cur_byte_s = shadow_q[7:0];
      default: cur_byte_s = 8'h00;
    endcase
  end

  assign bit_nxt_s = bit_q + 3'd1;
  assign bit_end_s = (cyc_q == CYC_LAST);

  // Next-state logic; tx_d is the line level for the cycle following the edge.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    shadow_d   = shadow_q;
    dbg_read_d = dbg_read_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        dbg_read_d = 5'd0;
        cyc_d      = '0;
        bit_d      = 3'd0;
        if (start) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        shadow_d = dbg_data;
        byte_d   = 2'd0;
        bit_d    = 3'd0;
        cyc_d    = '0;
        tx_d     = 1'b0;
        state_d  = S_START;
      end
      S_START: begin
        if (bit_end_s) begin
          cyc_d   = '0;
          bit_d   = 3'd0;
          tx_d    = cur_byte_s[0];
          state_d = S_DATA;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cyc_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d = bit_nxt_s;
            tx_d  = cur_byte_s[bit_nxt_s];
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          cyc_d = '0;
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            tx_d    = 1'b0;
            state_d = S_START;
          end else if (dbg_read_q != REG_LAST) begin
            dbg_read_d = dbg_read_q + 5'd1;
            tx_d       = 1'b1;
            state_d    = S_LOAD;
          end else begin
            dbg_read_d = 5'd0;
            tx_d       = 1'b1;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = S_IDLE;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        dbg_read_d = 5'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      bit_q      <= 3'd0;
      byte_q     <= 2'd0;
      shadow_q   <= 32'd0;
      dbg_read_q <= 5'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      shadow_q   <= shadow_d;
      dbg_read_q <= dbg_read_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign dbg_read = dbg_read_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_reg_dump_tx.sv
// Bench for reg_dump_tx: records the tx/busy/done/dbg_read trace each cycle and
// compares it with an ideal UART waveform built from the expected register values.
module tb_reg_dump_tx;

  localparam int C        = 4;
  localparam int LR       = 5;
  localparam int REG_CYC  = 1 + 40 * C;
  localparam int DUMP_CYC = (LR + 1) * REG_CYC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  dbg_read;
  logic [31:0] dbg_data;
  logic        tx, busy, done;

  logic [31:0] regs [32];
  logic [31:0] exp_vals [LR+1];
  int tests = 0;
  int fails = 0;

  bit tr_tx[$];
  bit tr_busy[$];
  bit tr_done[$];
  int tr_rd[$];

  reg_dump_tx #(.CLKS_PER_BIT(C), .LAST_REG(LR)) dut (
    .clk(clk), .rst(rst), .start(start), .dbg_read(dbg_read),
    .dbg_data(dbg_data), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign dbg_data = (dbg_read == 5'd0) ? 32'd0 : regs[dbg_read];

  always @(negedge clk) begin
    tr_tx.push_back(tx);
    tr_busy.push_back(busy);
    tr_done.push_back(done);
    tr_rd.push_back(int'(dbg_read));
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_trace();
    tr_tx.delete();
    tr_busy.delete();
    tr_done.delete();
    tr_rd.delete();
  endtask

  task automatic wait_done(string tag);
    int n = 0;
    while (done !== 1'b1 && n < 3 * DUMP_CYC) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done === 1'b1), 32'd1);
  endtask

  task automatic wait_reg(string tag, logic [4:0] idx);
    int n = 0;
    while (dbg_read !== idx && n < 3 * DUMP_CYC) begin
      tick();
      n++;
    end
    chk({tag, "_reg_reached"}, 32'(dbg_read === idx), 32'd1);
  endtask

  // Compares the recorded trace from busy rise against the ideal dump of exp_vals.
  task automatic check_dump(string tag);
    bit w[$];
    int b = -1;
    int mism = 0;
    int rd_bad = 0;
    int done_cnt = 0;
    int done_at = -1;
    for (int i = 0; i < tr_busy.size(); i++)
      if (tr_busy[i] && b < 0) b = i;
    chk({tag, "_busy_rise"}, 32'(b >= 0), 32'd1);
    if (b < 0) return;
    for (int r = 0; r <= LR; r++) begin
      w.push_back(1'b1);
      for (int k = 0; k < 4; k++) begin
        logic [7:0] by;
        by = 8'(exp_vals[r] >> (24 - 8 * k));
        repeat (C) w.push_back(1'b0);
        for (int j = 0; j < 8; j++) repeat (C) w.push_back(by[j]);
        repeat (C) w.push_back(1'b1);
      end
    end
    for (int i = 0; i < w.size(); i++)
      if (b + i >= tr_tx.size() || tr_tx[b + i] != w[i]) mism++;
    chk({tag, "_tx_wave_mismatches"}, 32'(mism), 32'd0);
    for (int r = 0; r <= LR; r++) begin
      for (int k = 0; k < 4; k++) begin
        logic [7:0] got;
        int idx;
        for (int j = 0; j < 8; j++) begin
          idx = b + r * REG_CYC + 1 + k * 10 * C + (1 + j) * C + C / 2;
          got[j] = (idx < tr_tx.size()) ? tr_tx[idx] : 1'b0;
        end
        chk($sformatf("%s_r%0d_byte%0d", tag, r, k), 32'(got),
            32'(8'(exp_vals[r] >> (24 - 8 * k))));
      end
    end
    for (int r = 0; r <= LR; r++)
      for (int c = 0; c < REG_CYC; c++)
        if (b + r * REG_CYC + c >= tr_rd.size() || tr_rd[b + r * REG_CYC + c] != r) rd_bad++;
    chk({tag, "_dbg_read_unstable"}, 32'(rd_bad), 32'd0);
    for (int i = b; i < tr_done.size(); i++)
      if (tr_done[i]) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, "_done_latency"}, 32'(done_at - b), 32'(DUMP_CYC));
    if (done_at > 0) begin
      chk({tag, "_busy_at_done"}, 32'(tr_busy[done_at]), 32'd0);
      chk({tag, "_busy_before_done"}, 32'(tr_busy[done_at - 1]), 32'd1);
      chk({tag, "_rd_at_done"}, 32'(tr_rd[done_at]), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;

    // Reset held three cycles with start high: no frame may start.
    rst = 1'b1;
    start = 1'b1;
    repeat (3) tick();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dbg_read", 32'(dbg_read), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    repeat (5) tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_tx", 32'(tx), 32'd1);

    // Dump 1: fixed patterns, snapshot mutation, starts ignored while busy.
    regs[1] = 32'hDEADBEEF;
    regs[2] = 32'hA5A5A5A5;
    regs[3] = 32'h11223344;
    exp_vals[0] = 32'd0;
    exp_vals[1] = 32'hDEADBEEF;
    exp_vals[2] = 32'hA5A5A5A5;
    exp_vals[3] = 32'h11223344;
    exp_vals[4] = $urandom;
    exp_vals[5] = regs[5];
    clear_trace();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_reg("d1", 5'd3);
    repeat (2) tick();
    regs[3] = 32'hFFFFFFFF;
    regs[4] = exp_vals[4];
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("d1");
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_dbg_read", 32'(dbg_read), 32'd0);
    check_dump("d1");

    // Dump 2 is cut by reset in the middle of register 5.
    wait_reg("d2", 5'd5);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_dbg_read", 32'(dbg_read), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    repeat (3) tick();
    chk("midrst_stays_idle", 32'(busy), 32'd0);

    // Dump 3: random contents, full dump from register 0.
    for (int i = 1; i <= LR; i++) begin
      regs[i] = $urandom;
      exp_vals[i] = regs[i];
    end
    exp_vals[0] = 32'd0;
    clear_trace();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("d3");
    repeat (2) tick();
    check_dump("d3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
